// File: rtl/bcd_scan_display_pkg.sv
// bcd_scan_display_pkg: shared digit count, segment codes and output polarities
package bcd_scan_display_pkg;
  localparam int DIGITS = 4;
  localparam logic SEG_ON = 1'b0;
  localparam logic AN_ON = 1'b0;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = {7{~SEG_ON}};
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{~AN_ON}};
endpackage

// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if: count controls in, count value and display drive out
interface bcd_scan_display_if;
  import bcd_scan_display_pkg::*;
  logic Tick, En, Clr, Wrap;
  logic [4*DIGITS-1:0] Digits;
  logic [6:0] Seg;
  logic [DIGITS-1:0] An;
  modport master(output Tick, En, Clr, input Digits, Wrap, Seg, An);
  modport slave(input Tick, En, Clr, output Digits, Wrap, Seg, An);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low gfedcba segment pattern
module seg7_decode import bcd_scan_display_pkg::*; (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // non-BCD codes cannot occur in the counter, so they just go dark
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: 4-digit BCD event counter with multiplexed 7-segment scan
module bcd_scan_display import bcd_scan_display_pkg::*; #(
  parameter int SCAN_BITS = 16
) (
  input logic Clk,
  input logic Rst,
  bcd_scan_display_if.slave bus
);
  logic [4*DIGITS-1:0] digits, inc;
  logic carry, wrap;
  logic [SCAN_BITS-1:0] scan;
  logic [1:0] sel;
  logic [3:0] nib;
  logic [6:0] dec, seg;
  logic [DIGITS-1:0] an;
  assign sel = scan[SCAN_BITS-1 -: 2];
  assign nib = digits[4*sel +: 4];
  seg7_decode u_dec (.bcd(nib), .seg(dec));
  // decimal increment with the carry rippling through every nibble in one cycle
  always_comb begin
    inc = digits;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i +: 4] = carry ? (digits[4*i +: 4] == 4'd9 ? 4'd0 : digits[4*i +: 4] + 4'd1) : digits[4*i +: 4];
      carry = carry && digits[4*i +: 4] == 4'd9;
    end
  end
  // count register: clear beats tick, carry out of the top digit is the wrap pulse
  always_ff @(posedge Clk) begin
    if (Rst || bus.Clr) begin
      digits <= '0;
      wrap <= 1'b0;
    end else begin
      digits <= bus.Tick && bus.En ? inc : digits;
      wrap <= bus.Tick && bus.En && carry;
    end
  end
  // free-running scan counter and registered display drive, dark while in reset
  always_ff @(posedge Clk) begin
    scan <= Rst ? '0 : scan + 1'b1;
    seg <= Rst ? SEG_BLANK : dec;
    an <= Rst ? AN_OFF : AN_OFF ^ (DIGITS'(1) << sel);
  end
  assign bus.Digits = digits;
  assign bus.Wrap = wrap;
  assign bus.Seg = seg;
  assign bus.An = an;
endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter: SCAN_BITS, 16, width of free-running digit-scan counter; digit select = its top 2 bits.
REQ-002 Parameter: DIGITS, 4, number of BCD digits; fixed at 4 in this revision.
REQ-003 Port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: Rst  input  1  reset; synchronous and active-high.
REQ-005 Port: Tick  input  1  count strobe; the frequency-divider output feeds it; one increment per sampled-high cycle.
REQ-006 Port: En  input  1  count enable; Tick ignored while low.
REQ-007 Port: Clr  input  1  synchronous clear of count value.
REQ-008 Port: Digits  output  16  current count, 4 BCD nibbles; [3:0] = units.
REQ-009 Port: Wrap  output  1  one-cycle pulse on 9999->0000 rollover.
REQ-010 Port: Seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 Port: An  output  4  digit anode enables, active-low, one-hot-zero, registered.

Function
REQ-012 Count update: cycle N with Tick=1, En=1, Clr=0 -> Digits incremented by 1 (decimal) visible at N+1.
REQ-013 Each nibble SHALL stay in 0..9; 9 + carry-in -> 0 with carry-out to next nibble, full ripple resolved in one cycle.
REQ-014 Rollover: 9999 + increment -> 0000, Wrap=1 for exactly the cycle Digits shows 0000 after rollover; otherwise Wrap=0.
REQ-015 Tick high on consecutive cycles SHALL increment on every such cycle (no edge detection).
REQ-016 Clr=1 SHALL force Digits=0000 next cycle, priority over Tick/En; Wrap=0 on clear.
REQ-017 En=0 SHALL hold Digits; Clr still acts.
REQ-018 Scan counter SHALL increment every cycle, wrap modulo 2^SCAN_BITS, independent of Tick/En/Clr.
REQ-019 Digit select s = scan[SCAN_BITS-1:SCAN_BITS-2]; An[s]=0, all other An bits=1.
REQ-020 Seg SHALL show decode of nibble s, registered together with An so both change in the same cycle (1-cycle latency from scan counter/Digits).
REQ-021 Decode table (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10-15 (unreachable) -> 1111111.
REQ-022 Count change mid-digit-slot SHALL appear on Seg the cycle after Digits changes; no blanking of leading zeros.

Reset
REQ-023 Rst=1 at a rising edge SHALL set Digits=0000, scan counter=0, Wrap=0, Seg=1111111, An=1111 (display dark) next cycle.
REQ-024 Rst SHALL override Clr, Tick and En; reset mid-count or mid-rollover discards the pending increment and Wrap.
REQ-025 First cycle after Rst deasserts: An=1110, Seg=1000000 (digit 0, value 0).

Structure
REQ-026 Shared package SHALL hold DIGITS, the segment encoding constants (SEG_0..SEG_9, SEG_BLANK) and the active-low polarity constants.
REQ-027 Segment decode SHALL be a sub-module seg7_decode (4-bit BCD in, 7-bit active-low out, combinational); the top module holds count, scan and output registers.

Verification
REQ-028 Reset: Rst high 2 cycles with Tick=1 -> Digits=0000, An=1111, Seg=1111111, Wrap=0; after release An=1110, Seg=1000000.
REQ-029 Carry ripple: load to 0999 via ticks, one Tick -> Digits=1000 next cycle, Wrap=0.
REQ-030 Rollover: from 9999 one Tick -> Digits=0000 and Wrap=1 for exactly one cycle.
REQ-031 Priority: Clr=1 and Tick=1 at 0042 -> 0000; En=0 with 10 Ticks at 0042 -> stays 0042.
REQ-032 Scan (SCAN_BITS=4): Digits=1234 -> An cycles 1110,1101,1011,0111 each held 4 cycles, Seg = SEG_4,SEG_3,SEG_2,SEG_1 respectively, repeating every 16 cycles.
REQ-033 Back-to-back Tick for 12 cycles from 0000 -> Digits=0012.
